dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Three-way arbiter and sequencer for the single-port data RAM behind `cpu`. It shares one RAM port between the CPU write channel (WRV/DMAW/DMO), the CPU read channel (RDV/DMS/DMAR), and an external program/data loader. It serialises their accesses through a small state machine and returns read data to the CPU on DMI/DMIE.

## Interface
Parameters:
- AW, 16, address width of all address ports
- DW, 16, data width of all data ports

Ports:
- CLK  in  1  single clock, rising edge
- RST  in  1  asynchronous, active-high reset
- WRV  in  1  CPU write request (level)
- DMAW  in  AW  CPU write address
- DMO  in  DW  CPU write data
- WDONE  out  1  CPU write complete, 1-cycle pulse
- RDV  in  1  CPU read request; only counts when DMS=1
- DMS  in  1  CPU data-memory select
- DMAR  in  AW  CPU read address
- DMI  out  DW  CPU read data, held until the next CPU read completes
- DMIE  out  1  CPU read data valid, 1-cycle pulse
- LDV  in  1  loader request (level)
- LDWE  in  1  loader request type: 1 = write, 0 = read
- LDA  in  AW  loader address
- LDD  in  DW  loader write data
- LDQ  out  DW  loader read data, held
- LDDONE  out  1  loader access complete, 1-cycle pulse
- RAM_A  out  AW  RAM address
- RAM_WD  out  DW  RAM write data
- RAM_EN  out  1  RAM enable
- RAM_WE  out  1  RAM write enable
- RAM_RD  in  DW  RAM read data, valid the cycle after an enabled read
- BUSY  out  1  high whenever state is not IDLE
- GNT_ID  out  2  current owner: 00 none, 01 CPU-W, 10 CPU-R, 11 loader

## Operation
- Requests:
  - CPU-W: WRV.
  - CPU-R: RDV & DMS.
  - L: LDV.
- A request must be held until its done pulse. Once latched, a transaction completes even if its request drops.
- States: IDLE, ACC, RD.
- IDLE:
  - If any unmasked request is present, pick a winner.
  - Latch its address, write data and type into RAM_A, RAM_WD and RAM_WE, and set GNT_ID.
  - Go to ACC. With no request, stay in IDLE.
- ACC:
  - RAM_EN=1. RAM_WE=1 only for a write.
  - For a write, go to IDLE.
  - For a read, go to RD.
- RD:
  - RAM_EN=0.
  - At the edge leaving RD, capture RAM_RD into DMI (CPU-R owner) or LDQ (loader owner).
  - Go to IDLE.
- Done pulses (WDONE, DMIE, LDDONE) are registered and asserted in the first IDLE cycle after the transaction.
- Masking: a requester whose done pulse is high in the current cycle is excluded from arbitration in that cycle. This prevents double service of a held request.
- Arbitration order is set by the configuration macro (see Configuration).
- GNT_ID returns to 00 in IDLE. RAM_A and RAM_WD hold their last values in IDLE; RAM_EN=RAM_WE=0.

## Timing
- Reset values:
  - State IDLE; BUSY=0; GNT_ID=00.
  - RAM_EN=RAM_WE=0; RAM_A=RAM_WD=0.
  - DMI=LDQ=0; WDONE=DMIE=LDDONE=0.
  - Round-robin pointer = loader.
- Write latency:
  - Request seen in IDLE at cycle 0.
  - ACC at cycle 1.
  - Done pulse at cycle 2.
  - Back-to-back writes run every 2 cycles.
- Read latency:
  - IDLE at cycle 0, ACC at cycle 1, RD at cycle 2.
  - DMI/LDQ valid and DMIE/LDDONE at cycle 3.
  - Back-to-back reads run every 3 cycles.
- A new grant may be made in the same IDLE cycle in which a done pulse is asserted, but only to a different requester.
- Simultaneous requests: one grant per IDLE cycle; the losers wait, and no request is ever dropped.
- Reset mid-transaction forces all outputs to their reset values immediately (asynchronously), with no done pulse. The interrupted RAM write may or may not have occurred.
- Addresses and data pass through unmodified; there is no arithmetic on them.

## Configuration
- `DMEM_ARB_RR_EN` defined:
  - Round-robin arbitration.
  - Priority starts at the requester after the last granted one, in cyclic order CPU-W → CPU-R → L → CPU-W.
  - The pointer updates on each grant.
- Undefined:
  - Fixed priority CPU-W > CPU-R > L.
  - No pointer register; a continuously requesting CPU can starve the loader.

## Test plan
- Reset, then WRV=1, DMAW=0x0010, DMO=0xBEEF held → RAM_EN=RAM_WE=1 with RAM_A=0x0010, RAM_WD=0xBEEF at cycle 1; WDONE=1 at cycle 2; no second write while WRV drops in cycle 3.
- Preload RAM[0x0020]=0x1234; RDV=DMS=1, DMAR=0x0020 → RAM_EN=1, RAM_WE=0 at cycle 1; DMI=0x1234, DMIE=1 at cycle 3; RDV=1 with DMS=0 → never granted.
- WRV, RDV&DMS and LDV all asserted from reset and held after each done, with `DMEM_ARB_RR_EN` → grant order W, R, L, W, R, L (GNT_ID 01, 10, 11, ...). Without the macro → W repeats and L is never granted.
- Loader write LDA=0x0005, LDD=0x00AA, then loader read LDA=0x0005 with LDWE=0 → LDDONE pulses at cycles 2 and 7; LDQ=0x00AA; DMI unchanged.
- RST asserted during ACC of a write → RAM_EN, RAM_WE, BUSY and GNT_ID drop within the same cycle with no WDONE; after release, a held WRV restarts from IDLE with the full 2-cycle latency.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: CPU write/read channels, loader channel and the RAM port.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface dmem_arbiter_if #(
   parameter int AW = 16,
   parameter int DW = 16
);
   logic          WRV;
   logic [AW-1:0] DMAW;
   logic [DW-1:0] DMO;
   logic          WDONE;
   logic          RDV;
   logic          DMS;
   logic [AW-1:0] DMAR;
   logic [DW-1:0] DMI;
   logic          DMIE;
   logic          LDV;
   logic          LDWE;
   logic [AW-1:0] LDA;
   logic [DW-1:0] LDD;
   logic [DW-1:0] LDQ;
   logic          LDDONE;
   logic [AW-1:0] RAM_A;
   logic [DW-1:0] RAM_WD;
   logic          RAM_EN;
   logic          RAM_WE;
   logic [DW-1:0] RAM_RD;
   logic          BUSY;
   logic [1:0]    GNT_ID;

   modport slave (
      input  WRV, DMAW, DMO, RDV, DMS, DMAR, LDV, LDWE, LDA, LDD, RAM_RD,
      output WDONE, DMI, DMIE, LDQ, LDDONE, RAM_A, RAM_WD, RAM_EN, RAM_WE, BUSY, GNT_ID
   );

   modport master (
      output WRV, DMAW, DMO, RDV, DMS, DMAR, LDV, LDWE, LDA, LDD, RAM_RD,
      input  WDONE, DMI, DMIE, LDQ, LDDONE, RAM_A, RAM_WD, RAM_EN, RAM_WE, BUSY, GNT_ID
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Three-way arbiter/sequencer sharing one data-RAM port between CPU write, CPU read and loader.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority CPU-W > CPU-R > L.
module dmem_arbiter #(
   parameter int AW = 16,
   parameter int DW = 16
) (
   input  logic           CLK,
   input  logic           RST,
   dmem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, ACC, RD} state_t;

   localparam logic [1:0] ID_NONE = 2'd0;
   localparam logic [1:0] ID_CPUW = 2'd1;
   localparam logic [1:0] ID_CPUR = 2'd2;
   localparam logic [1:0] ID_LD   = 2'd3;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [1:0]    r_owner;
   logic          r_we;
   logic [AW-1:0] r_ram_a;
   logic [DW-1:0] r_ram_wd;
   logic [DW-1:0] r_dmi;
   logic [DW-1:0] r_ldq;
   logic          r_wdone;
   logic          r_dmie;
   logic          r_lddone;

   logic [2:0]    w_req;
   logic [1:0]    w_start;
   logic [1:0]    w_gnt;
   logic [AW-1:0] w_sel_a;
   logic [DW-1:0] w_sel_wd;
   logic          w_sel_we;

   // A requester whose done pulse is up is still holding its level request; skip it this cycle.
   assign w_req = {bus.LDV & ~r_lddone, bus.RDV & bus.DMS & ~r_dmie, bus.WRV & ~r_wdone};

   // Scan the three requesters cyclically from index 'start'; returns the owner id or ID_NONE.
   function automatic logic [1:0] f_pick(input logic [2:0] req, input logic [1:0] start);
      logic [1:0] idx;
      f_pick = ID_NONE;
      for (int k = 2; k >= 0; k--) begin
         idx = 2'((int'(start) + k) % 3);
         if (req[idx]) f_pick = idx + 2'd1;
      end
   endfunction

`ifdef DMEM_ARB_RR_EN
   logic [1:0] r_last;

   assign w_start = (r_last == ID_LD) ? 2'd0 : r_last;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)                                     r_last <= ID_LD;
      else if (r_state == IDLE && w_gnt != ID_NONE) r_last <= w_gnt;
   end
`else
   assign w_start = 2'd0;
`endif

   assign w_gnt = (r_state == IDLE) ? f_pick(w_req, w_start) : ID_NONE;

   // NOTE: every variable written here gets a default first so no latch is inferred.
   always_comb begin
      w_sel_a  = r_ram_a;
      w_sel_wd = r_ram_wd;
      w_sel_we = 1'b0;
      case (w_gnt)
         ID_CPUW: begin w_sel_a = bus.DMAW; w_sel_wd = bus.DMO; w_sel_we = 1'b1;     end
         ID_CPUR: begin w_sel_a = bus.DMAR;                                           end
         ID_LD:   begin w_sel_a = bus.LDA;  w_sel_wd = bus.LDD; w_sel_we = bus.LDWE; end
         default: ;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_gnt != ID_NONE) w_state_nxt = ACC;
         ACC:     w_state_nxt = r_we ? IDLE : RD;
         RD:      w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_owner  <= ID_NONE;
         r_we     <= 1'b0;
         r_ram_a  <= '0;
         r_ram_wd <= '0;
         r_dmi    <= '0;
         r_ldq    <= '0;
         r_wdone  <= 1'b0;
         r_dmie   <= 1'b0;
         r_lddone <= 1'b0;
      end else begin
         r_wdone  <= 1'b0;
         r_dmie   <= 1'b0;
         r_lddone <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_gnt != ID_NONE) begin
                  r_owner  <= w_gnt;
                  r_we     <= w_sel_we;
                  r_ram_a  <= w_sel_a;
                  r_ram_wd <= w_sel_wd;
               end
            end
            ACC: begin
               if (r_we) begin
                  r_wdone  <= (r_owner == ID_CPUW);
                  r_lddone <= (r_owner == ID_LD);
                  r_owner  <= ID_NONE;
               end
            end
            RD: begin
               if (r_owner == ID_CPUR) begin
                  r_dmi  <= bus.RAM_RD;
                  r_dmie <= 1'b1;
               end else begin
                  r_ldq    <= bus.RAM_RD;
                  r_lddone <= 1'b1;
               end
               r_owner <= ID_NONE;
            end
            default: r_owner <= ID_NONE;
         endcase
      end
   end

   assign bus.RAM_A  = r_ram_a;
   assign bus.RAM_WD = r_ram_wd;
   assign bus.RAM_EN = (r_state == ACC);
   assign bus.RAM_WE = (r_state == ACC) & r_we;
   assign bus.BUSY   = (r_state != IDLE);
   assign bus.GNT_ID = r_owner;
   assign bus.DMI    = r_dmi;
   assign bus.DMIE   = r_dmie;
   assign bus.LDQ    = r_ldq;
   assign bus.LDDONE = r_lddone;
   assign bus.WDONE  = r_wdone;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed stimulus, a RAM model, and a scoreboard of
// expected grants and completions popped by a negedge monitor.
module tb_dmem_arbiter;
   localparam int AW = 16;
   localparam int DW = 16;

   typedef struct {
      logic [1:0]    kind;
      logic          chk;
      logic [DW-1:0] data;
   } exp_t;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   exp_t          q_done[$];
   logic [1:0]    q_gnt[$];
   logic [1:0]    seq[$];
   logic [DW-1:0] ram [0:(1<<AW)-1];
   logic [1:0]    m_kind;
   exp_t          m_exp;
   bit            more_w, more_r, more_l;
   int            g;
   int            n_busy;

   always #5 CLK = ~CLK;

   dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
   dmem_arbiter #(.AW(AW), .DW(DW)) u_dut (.CLK(CLK), .RST(RST), .bus(bus));

   // NOTE: the RAM array is never reset; only control state needs a known value after reset.
   always @(posedge CLK) begin
      if (bus.RAM_EN === 1'b1) begin
         if (bus.RAM_WE === 1'b1) ram[bus.RAM_A] <= bus.RAM_WD;
         else                     bus.RAM_RD     <= ram[bus.RAM_A];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drop_all();
      bus.WRV = 1'b0;
      bus.RDV = 1'b0;
      bus.LDV = 1'b0;
   endtask

   // Scoreboard monitor: each ACC cycle consumes one expected grant, each done pulse one completion.
   always @(negedge CLK) begin
      if (bus.RAM_EN === 1'b1) begin
         if (q_gnt.size() == 0) check("unexpected_grant", 32'(bus.GNT_ID), 32'd0);
         else                   check("grant_order", 32'(bus.GNT_ID), 32'(q_gnt.pop_front()));
      end
      if (bus.WDONE === 1'b1 || bus.DMIE === 1'b1 || bus.LDDONE === 1'b1) begin
         m_kind = (bus.WDONE === 1'b1) ? 2'd1 : (bus.DMIE === 1'b1) ? 2'd2 : 2'd3;
         if (q_done.size() == 0) begin
            check("unexpected_done", 32'(m_kind), 32'd0);
         end else begin
            m_exp = q_done.pop_front();
            check("done_kind", 32'(m_kind), 32'(m_exp.kind));
            if (m_exp.chk) check("done_data", 32'((m_kind == 2'd2) ? bus.DMI : bus.LDQ), 32'(m_exp.data));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      drop_all();
      bus.DMAW = '0; bus.DMO = '0; bus.DMS = 1'b0; bus.DMAR = '0;
      bus.LDWE = 1'b0; bus.LDA = '0; bus.LDD = '0; bus.RAM_RD = '0;
      ram[16'h0020] = 16'h1234;

      // Reset state
      #1 RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      check("rst_busy",   32'(bus.BUSY), 32'd0);
      check("rst_gnt",    32'(bus.GNT_ID), 32'd0);
      check("rst_ram_ctl", 32'({bus.RAM_EN, bus.RAM_WE}), 32'd0);
      check("rst_ram_a",  32'(bus.RAM_A), 32'd0);
      check("rst_ram_wd", 32'(bus.RAM_WD), 32'd0);
      check("rst_dmi_ldq", 32'({bus.DMI, bus.LDQ}), 32'd0);
      check("rst_pulses", 32'({bus.WDONE, bus.DMIE, bus.LDDONE}), 32'd0);

      // CPU write, cycle 0 is the first cycle after release
      RST = 1'b0;
      bus.WRV = 1'b1; bus.DMAW = 16'h0010; bus.DMO = 16'hBEEF;
      q_gnt.push_back(2'd1); q_done.push_back('{2'd1, 1'b0, '0});
      step();
      check("w_c1_en_we", 32'({bus.RAM_EN, bus.RAM_WE}), 32'b11);
      check("w_c1_addr",  32'(bus.RAM_A), 32'h0010);
      check("w_c1_data",  32'(bus.RAM_WD), 32'hBEEF);
      check("w_c1_gnt",   32'(bus.GNT_ID), 32'd1);
      step();
      check("w_c2_wdone", 32'(bus.WDONE), 32'd1);
      check("w_c2_idle",  32'({bus.BUSY, bus.GNT_ID}), 32'd0);
      bus.WRV = 1'b0;
      step();
      check("w_c3_no_rewrite", 32'({bus.BUSY, bus.RAM_EN, bus.WDONE}), 32'd0);
      step();

      // CPU read of preloaded word
      bus.RDV = 1'b1; bus.DMS = 1'b1; bus.DMAR = 16'h0020;
      q_gnt.push_back(2'd2); q_done.push_back('{2'd2, 1'b1, 16'h1234});
      step();
      check("r_c1_en_we", 32'({bus.RAM_EN, bus.RAM_WE}), 32'b10);
      check("r_c1_addr",  32'(bus.RAM_A), 32'h0020);
      check("r_c1_wd_held", 32'(bus.RAM_WD), 32'hBEEF);
      step();
      check("r_c2_rd", 32'({bus.BUSY, bus.RAM_EN, bus.DMIE}), 32'b100);
      step();
      check("r_c3_dmie", 32'(bus.DMIE), 32'd1);
      check("r_c3_dmi",  32'(bus.DMI), 32'h1234);
      bus.RDV = 1'b0;
      step();
      check("r_dmi_held", 32'({bus.DMIE, bus.DMI}), 32'h1234);

      // RDV without DMS is not a request
      bus.RDV = 1'b1; bus.DMS = 1'b0;
      n_busy = 0;
      repeat (10) begin
         step();
         if (bus.BUSY === 1'b1) n_busy++;
      end
      check("dms0_never_granted", 32'(n_busy), 32'd0);
      bus.RDV = 1'b0;

      // Loader write then loader read of the same word
      bus.LDV = 1'b1; bus.LDWE = 1'b1; bus.LDA = 16'h0005; bus.LDD = 16'h00AA;
      q_gnt.push_back(2'd3); q_done.push_back('{2'd3, 1'b0, '0});
      step();
      check("lw_c1_we",   32'({bus.RAM_EN, bus.RAM_WE, bus.GNT_ID}), 32'b1111);
      check("lw_c1_addr", 32'({bus.RAM_A, bus.RAM_WD}), 32'h0005_00AA);
      step();
      check("lw_c2_lddone", 32'(bus.LDDONE), 32'd1);
      bus.LDV = 1'b0;
      step();
      step();
      bus.LDV = 1'b1; bus.LDWE = 1'b0;
      q_gnt.push_back(2'd3); q_done.push_back('{2'd3, 1'b1, 16'h00AA});
      step();
      check("lr_c5_en_we", 32'({bus.RAM_EN, bus.RAM_WE}), 32'b10);
      step();
      check("lr_c6_no_done", 32'({bus.BUSY, bus.LDDONE}), 32'b10);
      step();
      check("lr_c7_lddone", 32'(bus.LDDONE), 32'd1);
      check("lr_c7_ldq",    32'(bus.LDQ), 32'h00AA);
      check("lr_dmi_unchanged", 32'(bus.DMI), 32'h1234);
      bus.LDV = 1'b0;
      step();

      // All three requesters held; last grant so far was the loader
`ifdef DMEM_ARB_RR_EN
      seq = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};
`else
      seq = '{2'd1, 2'd2, 2'd1, 2'd2};
`endif
      foreach (seq[i]) begin
         q_gnt.push_back(seq[i]);
         case (seq[i])
            2'd1:    q_done.push_back('{2'd1, 1'b0, '0});
            2'd2:    q_done.push_back('{2'd2, 1'b1, 16'h1234});
            default: q_done.push_back('{2'd3, 1'b0, '0});
         endcase
      end
      bus.WRV = 1'b1; bus.DMAW = 16'h0040; bus.DMO = 16'h7777;
      bus.RDV = 1'b1; bus.DMS = 1'b1; bus.DMAR = 16'h0020;
      bus.LDV = 1'b1; bus.LDWE = 1'b1; bus.LDA = 16'h0030; bus.LDD = 16'h5555;
      g = 0;
      for (int c = 0; c < 80 && g < seq.size(); c++) begin
         step();
         if (bus.RAM_EN === 1'b1) begin
            g++;
            if (g == seq.size()) begin
               drop_all();
            end else begin
               more_w = 1'b0; more_r = 1'b0; more_l = 1'b0;
               for (int k = g; k < seq.size(); k++) begin
                  if (seq[k] == 2'd1) more_w = 1'b1;
                  if (seq[k] == 2'd2) more_r = 1'b1;
                  if (seq[k] == 2'd3) more_l = 1'b1;
               end
               if (!more_w) bus.WRV = 1'b0;
               if (!more_r) bus.RDV = 1'b0;
`ifdef DMEM_ARB_RR_EN
               if (!more_l) bus.LDV = 1'b0;
`endif
            end
         end
      end
      check("arb_grant_count", 32'(g), 32'(seq.size()));
      repeat (6) step();
      check("arb_grants_left", 32'(q_gnt.size()), 32'd0);
      check("arb_dones_left",  32'(q_done.size()), 32'd0);

      // Reset during ACC of a CPU write; only the restarted write completes
      bus.WRV = 1'b1; bus.DMAW = 16'h0050; bus.DMO = 16'h1111;
      q_gnt.push_back(2'd1); q_done.push_back('{2'd1, 1'b0, '0});
      step();
      check("rst_mid_acc", 32'({bus.RAM_EN, bus.RAM_WE}), 32'b11);
      #2 RST = 1'b1;
      #1;
      check("rst_mid_ram_ctl", 32'({bus.RAM_EN, bus.RAM_WE}), 32'd0);
      check("rst_mid_busy_gnt", 32'({bus.BUSY, bus.GNT_ID}), 32'd0);
      @(posedge CLK);
      #1;
      check("rst_mid_no_wdone", 32'(bus.WDONE), 32'd0);
      RST = 1'b0;
      step();
      check("rst_restart_c1", 32'({bus.RAM_EN, bus.RAM_WE, bus.GNT_ID}), 32'b1101);
      check("rst_restart_addr", 32'(bus.RAM_A), 32'h0050);
      step();
      check("rst_restart_c2_wdone", 32'(bus.WDONE), 32'd1);
      bus.WRV = 1'b0;
      repeat (4) step();
      check("final_grants_left", 32'(q_gnt.size()), 32'd0);
      check("final_dones_left",  32'(q_done.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
